// File: rtl/icape2_pkg.sv
// Shared constants, FSM state type and the byte bit-reverse helper for the
// ICAPE2 responder and the Wishbone bridge that drives it.
package icape2_pkg;

  localparam logic [31:0] SYNC_WORD  = 32'hAA995566;
  localparam logic [31:0] NOOP_WORD  = 32'h20000000;
  localparam logic [31:0] DUMMY_WORD = 32'hFFFFFFFF;

  localparam logic [2:0] TYPE1 = 3'b001;

  localparam logic [1:0] OP_NOOP  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam logic [4:0] REG_CMD    = 5'h04;
  localparam logic [4:0] REG_STAT   = 5'h07;
  localparam logic [4:0] REG_IDCODE = 5'h0C;
  localparam logic [4:0] REG_WBSTAR = 5'h10;

  localparam logic [4:0] CMD_DESYNC = 5'h0D;
  localparam logic [4:0] CMD_IPROG  = 5'h0F;

  typedef enum logic [1:0] {
    ST_UNSYNC,
    ST_HDR,
    ST_WDATA,
    ST_RPEND
  } state_t;

  // ICAPE2 pins carry each byte MSB/LSB swapped relative to the bitstream.
  function automatic logic [31:0] bitrev_bytes(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[b*8+i] = d[b*8+7-i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/icape2_shadow_regs.sv
// 32x32 shadow configuration registers: one write port, a registered read
// port that doubles as the read buffer, read-only masking and the WBSTAR tap.
module icape2_shadow_regs
  import icape2_pkg::*;
#(
  parameter logic [31:0] IDCODE = 32'h0362D093
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re,
  input  logic [4:0]  raddr,
  input  logic [1:0]  stat,
  output logic [31:0] rdata,
  output logic [31:0] wbstar
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      rdata <= '0;
    end else begin
      // IDCODE and STAT are synthesised on read, so writes to them vanish.
      if (we && waddr != REG_IDCODE && waddr != REG_STAT) regs[waddr] <= wdata;
      if (re) begin
        case (raddr)
          REG_IDCODE: rdata <= IDCODE;
          REG_STAT:   rdata <= {30'h0, stat};
          default:    rdata <= regs[raddr];
        endcase
      end
    end
  end

  assign wbstar = regs[REG_WBSTAR];

endmodule

// File: rtl/icape2_responder.sv
// Far-end ICAPE2 model: SYNC detection, type-1 packet decode, shadow register
// file, delayed read return and CMD (IPROG/DESYNC) handling.
module icape2_responder
  import icape2_pkg::*;
#(
  parameter logic [31:0] IDCODE   = 32'h0362D093,
  parameter int          READ_LAT = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_csib,
  input  logic        i_rdwrb,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_synced,
  output logic        o_iprog,
  output logic [31:0] o_wbstar,
  output logic        o_err
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

  state_t      state, state_nxt;
  logic [10:0] cnt, cnt_nxt;
  logic [4:0]  addr, addr_nxt;
  logic [2:0]  lat_cnt, lat_nxt;
  logic        synced_nxt, err_nxt, iprog_nxt;
  logic [31:0] data_nxt;
  logic        prev_active, prev_rdwrb;

  logic [31:0] w, rbuf;
  logic        we, re, hdr_decode, dir_switch;
  logic [10:0] hdr_cnt;
  logic [4:0]  hdr_addr;

  assign w          = bitrev_bytes(i_data);
  assign hdr_addr   = w[17:13];
  assign hdr_cnt    = w[10:0];
  assign dir_switch = !i_csib && prev_active && (i_rdwrb != prev_rdwrb);

  icape2_shadow_regs #(.IDCODE(IDCODE)) u_regs (
    .clk    (i_clk),
    .rst    (i_reset),
    .we     (we),
    .waddr  (addr),
    .wdata  (w),
    .re     (re),
    .raddr  (hdr_addr),
    .stat   ({o_err, o_synced}),
    .rdata  (rbuf),
    .wbstar (o_wbstar)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_UNSYNC;
      cnt         <= '0;
      addr        <= '0;
      lat_cnt     <= '0;
      o_data      <= 32'hFFFFFFFF;
      o_synced    <= 1'b0;
      o_iprog     <= 1'b0;
      o_err       <= 1'b0;
      prev_active <= 1'b0;
      prev_rdwrb  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      addr        <= addr_nxt;
      lat_cnt     <= lat_nxt;
      o_data      <= data_nxt;
      o_synced    <= synced_nxt;
      o_iprog     <= iprog_nxt;
      o_err       <= err_nxt;
      prev_active <= !i_csib;
      prev_rdwrb  <= i_rdwrb;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    addr_nxt   = addr;
    lat_nxt    = lat_cnt;
    data_nxt   = o_data;
    synced_nxt = o_synced;
    err_nxt    = o_err;
    iprog_nxt  = 1'b0;
    we         = 1'b0;
    re         = 1'b0;
    hdr_decode = 1'b0;

    if (!i_csib) begin
      if (dir_switch) begin
        err_nxt = 1'b1;
      end else if (i_rdwrb) begin
        if (state == ST_RPEND) begin
          if (lat_cnt == LAT_LAST) begin
            data_nxt  = bitrev_bytes(rbuf);
            lat_nxt   = '0;
            state_nxt = ST_HDR;
          end else begin
            lat_nxt = lat_cnt + 3'd1;
          end
        end
      end else begin
        case (state)
          ST_UNSYNC: begin
            if (w == SYNC_WORD) begin
              state_nxt  = ST_HDR;
              synced_nxt = 1'b1;
            end
          end
          ST_HDR: hdr_decode = 1'b1;
          ST_WDATA: begin
            we      = 1'b1;
            cnt_nxt = cnt - 11'd1;
            if (cnt == 11'd1) state_nxt = ST_HDR;
            if (addr == REG_CMD && w[4:0] == CMD_IPROG) iprog_nxt = 1'b1;
            if (addr == REG_CMD && w[4:0] == CMD_DESYNC) begin
              state_nxt  = ST_UNSYNC;
              synced_nxt = 1'b0;
            end
          end
          ST_RPEND: begin
            // The bridge pads the read header with NOOPs before switching
            // direction; only a real packet word abandons the pending read.
            if (w != NOOP_WORD && w != DUMMY_WORD) begin
              err_nxt    = 1'b1;
              lat_nxt    = '0;
              state_nxt  = ST_HDR;
              hdr_decode = 1'b1;
            end
          end
          default: state_nxt = ST_UNSYNC;
        endcase

        if (hdr_decode && w != DUMMY_WORD) begin
          if (w[31:29] != TYPE1) begin
            err_nxt = 1'b1;
          end else begin
            case (w[28:27])
              OP_NOOP: ;
              OP_WRITE: begin
                if (hdr_cnt != 11'd0) begin
                  state_nxt = ST_WDATA;
                  cnt_nxt   = hdr_cnt;
                  addr_nxt  = hdr_addr;
                end
              end
              OP_READ: begin
                if (hdr_cnt == 11'd1) begin
                  re        = 1'b1;
                  lat_nxt   = '0;
                  state_nxt = ST_RPEND;
                end else begin
                  err_nxt = 1'b1;
                end
              end
              default: err_nxt = 1'b1;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_icape2_responder.sv
// Directed self-checking bench for icape2_responder.
module tb_icape2_responder;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_csib = 1'b1;
  logic        i_rdwrb = 1'b0;
  logic [31:0] i_data = 32'hFFFFFFFF;
  logic [31:0] o_data;
  logic        o_synced;
  logic        o_iprog;
  logic [31:0] o_wbstar;
  logic        o_err;

  int checks = 0;
  int errors = 0;

  icape2_responder dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_csib   (i_csib),
    .i_rdwrb  (i_rdwrb),
    .i_data   (i_data),
    .o_data   (o_data),
    .o_synced (o_synced),
    .o_iprog  (o_iprog),
    .o_wbstar (o_wbstar),
    .o_err    (o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] brev(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[(i/8)*8 + 7 - (i%8)] = d[i];
    return r;
  endfunction

  task automatic cyc(input logic csib, input logic rdwrb, input logic [31:0] word);
    i_csib  = csib;
    i_rdwrb = rdwrb;
    i_data  = brev(word);
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] word);
    cyc(1'b0, 1'b0, word);
  endtask

  task automatic rd();
    cyc(1'b0, 1'b1, 32'hFFFFFFFF);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 32'hFFFFFFFF);
  endtask

  task automatic apply_reset();
    i_csib  = 1'b1;
    i_rdwrb = 1'b0;
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    idle();
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    #2;
    checks++;
    if (o_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_data: got %h expected ffffffff", o_data); end
    checks++;
    if (o_synced !== 1'b0) begin errors++; $display("FAIL reset_synced: got %b expected 0", o_synced); end
    checks++;
    if (o_iprog !== 1'b0) begin errors++; $display("FAIL reset_iprog: got %b expected 0", o_iprog); end
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", o_err); end
    checks++;
    if (o_wbstar !== 32'h0) begin errors++; $display("FAIL reset_wbstar: got %h expected 00000000", o_wbstar); end
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    idle();
  endtask

  task automatic test_write_flow();
    apply_reset();
    wr(32'hFFFFFFFF); wr(32'h20000000);
    checks++;
    if (o_synced !== 1'b0) begin errors++; $display("FAIL wf_presync: got %b expected 0", o_synced); end
    wr(32'hAA995566);
    checks++;
    if (o_synced !== 1'b1) begin errors++; $display("FAIL wf_sync: got %b expected 1", o_synced); end
    wr(32'h20000000); wr(32'h20000000);
    wr(32'h30020001); wr(32'h12345678);
    checks++;
    if (o_wbstar !== 32'h12345678) begin errors++; $display("FAIL wf_wbstar: got %h expected 12345678", o_wbstar); end
    wr(32'h20000000); wr(32'h20000000);
    wr(32'h30008001);
    checks++;
    if (o_synced !== 1'b1) begin errors++; $display("FAIL wf_before_desync: got %b expected 1", o_synced); end
    wr(32'h0000000D);
    checks++;
    if (o_synced !== 1'b0) begin errors++; $display("FAIL wf_desync: got %b expected 0", o_synced); end
    wr(32'h20000000); wr(32'h20000000);
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL wf_err: got %b expected 0", o_err); end
    checks++;
    if (o_wbstar !== 32'h12345678) begin errors++; $display("FAIL wf_wbstar_hold: got %h expected 12345678", o_wbstar); end
  endtask

  task automatic test_read_flow();
    apply_reset();
    wr(32'hAA995566); wr(32'h28018001); wr(32'h20000000); wr(32'h20000000);
    idle();
    rd(); rd();
    checks++;
    if (o_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL rf_early: got %h expected ffffffff", o_data); end
    rd();
    checks++;
    if (o_data !== brev(32'h0362D093)) begin errors++; $display("FAIL rf_idcode: got %h expected %h", o_data, brev(32'h0362D093)); end
    rd();
    checks++;
    if (o_data !== brev(32'h0362D093)) begin errors++; $display("FAIL rf_hold: got %h expected %h", o_data, brev(32'h0362D093)); end
    idle();
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL rf_err: got %b expected 0", o_err); end
  endtask

  task automatic test_iprog();
    apply_reset();
    wr(32'hAA995566); wr(32'h30008001);
    checks++;
    if (o_iprog !== 1'b0) begin errors++; $display("FAIL ip_before: got %b expected 0", o_iprog); end
    wr(32'h0000000F);
    checks++;
    if (o_iprog !== 1'b1) begin errors++; $display("FAIL ip_pulse: got %b expected 1", o_iprog); end
    wr(32'h20000000);
    checks++;
    if (o_iprog !== 1'b0) begin errors++; $display("FAIL ip_one_cycle: got %b expected 0", o_iprog); end
    checks++;
    if (o_synced !== 1'b1) begin errors++; $display("FAIL ip_synced: got %b expected 1", o_synced); end
  endtask

  task automatic test_presync();
    apply_reset();
    wr(32'h30020001); wr(32'hDEADBEEF); wr(32'h20000000);
    checks++;
    if (o_wbstar !== 32'h0) begin errors++; $display("FAIL ps_wbstar: got %h expected 00000000", o_wbstar); end
    checks++;
    if (o_synced !== 1'b0) begin errors++; $display("FAIL ps_synced: got %b expected 0", o_synced); end
  endtask

  task automatic test_dir_error();
    apply_reset();
    wr(32'hAA995566); wr(32'h20000000);
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL de_before: got %b expected 0", o_err); end
    rd();
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL de_err: got %b expected 1", o_err); end
    idle();
    wr(32'h2800E001); wr(32'h20000000);
    idle();
    rd(); rd(); rd();
    checks++;
    if (o_data !== brev(32'h00000003)) begin errors++; $display("FAIL de_stat: got %h expected %h", o_data, brev(32'h00000003)); end
  endtask

  task automatic test_read_cnt2();
    apply_reset();
    wr(32'hAA995566); wr(32'h28018002);
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL rc2_err: got %b expected 1", o_err); end
    wr(32'h30020001); wr(32'hCAFEF00D);
    checks++;
    if (o_wbstar !== 32'hCAFEF00D) begin errors++; $display("FAIL rc2_hdr: got %h expected cafef00d", o_wbstar); end
  endtask

  task automatic test_abandon();
    apply_reset();
    wr(32'hAA995566); wr(32'h28018001); wr(32'h30020001);
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL ab_err: got %b expected 1", o_err); end
    wr(32'h55AA55AA);
    checks++;
    if (o_wbstar !== 32'h55AA55AA) begin errors++; $display("FAIL ab_wbstar: got %h expected 55aa55aa", o_wbstar); end
    idle();
    rd(); rd(); rd();
    checks++;
    if (o_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL ab_noread: got %h expected ffffffff", o_data); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    wr(32'hAA995566); wr(32'h30020001); wr(32'h11111111);
    checks++;
    if (o_wbstar !== 32'h11111111) begin errors++; $display("FAIL rm_pre: got %h expected 11111111", o_wbstar); end
    wr(32'h30020001);
    i_csib  = 1'b1;
    i_reset = 1'b1;
    #2;
    checks++;
    if (o_wbstar !== 32'h0) begin errors++; $display("FAIL rm_wbstar: got %h expected 00000000", o_wbstar); end
    checks++;
    if (o_synced !== 1'b0) begin errors++; $display("FAIL rm_synced: got %b expected 0", o_synced); end
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    idle();
    wr(32'hABCD0123); wr(32'h20000000);
    checks++;
    if (o_wbstar !== 32'h0) begin errors++; $display("FAIL rm_after: got %h expected 00000000", o_wbstar); end
    checks++;
    if (o_synced !== 1'b0) begin errors++; $display("FAIL rm_after_synced: got %b expected 0", o_synced); end
  endtask

  initial begin
    #3;
    test_reset();
    test_write_flow();
    test_read_flow();
    test_iprog();
    test_presync();
    test_dir_error();
    test_read_cnt2();
    test_abandon();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
